// File: rtl/addsub_accumulator_pkg.sv
// addsub_accumulator_pkg: op and FSM state encodings shared by the accumulator
package addsub_accumulator_pkg;
  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_HOLD} state_t;
endpackage

// File: rtl/addsub_core.sv
// addsub_core: ripple-carry adder-subtractor, subtract as a + ~b + 1
module addsub_core #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry_out,
  output logic         ovf
);
  logic [W:0]   c;
  logic [W-1:0] bx;
  assign bx   = b ^ {W{sub}};
  assign c[0] = sub;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end
  assign carry_out = c[W];
  assign ovf       = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
endmodule

// File: rtl/addsub_accumulator.sv
// addsub_accumulator: handshaked accumulator stage around addsub_core
module addsub_accumulator #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [W-1:0]     operand,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     acc,
  output logic             carry,
  output logic             ovf,
  output logic [CNT_W-1:0] op_cnt
);
  import addsub_accumulator_pkg::*;
  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     operand_q, operand_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     sum;
  logic             core_carry, core_ovf;
  addsub_core #(.W(W)) u_core (
    .a        (acc_q),
    .b        (operand_q),
    .sub      (op_q == OP_SUB),
    .sum      (sum),
    .carry_out(core_carry),
    .ovf      (core_ovf)
  );
  assign in_ready  = state_q == ST_IDLE;
  assign res_valid = state_q == ST_HOLD;
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign op_cnt    = cnt_q;
  // next state: latch op in IDLE, apply it in EXEC, count the handoff out of HOLD
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        state_d   = ST_EXEC;
        op_d      = op;
        operand_d = operand;
      end
      ST_EXEC: begin
        state_d = ST_HOLD;
        acc_d   = op_q == OP_CLR ? '0 : op_q == OP_LOAD ? operand_q : sum;
        carry_d = op_q[1] & core_carry;
        ovf_d   = op_q[1] & core_ovf;
      end
      ST_HOLD: if (res_ready) begin
        state_d = ST_IDLE;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_CLR;
      operand_q <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_addsub_accumulator.sv
// tb_addsub_accumulator: random and directed checks against an arithmetic model
module tb_addsub_accumulator;
  logic       clk = 0;
  logic       rst_b = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [1:0] op = 0;
  logic [7:0] operand = 0;
  logic       res_valid;
  logic       res_ready = 0;
  logic [7:0] acc;
  logic       carry;
  logic       ovf;
  logic [7:0] op_cnt;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] m_acc = 0;
  logic       m_c = 0;
  logic       m_v = 0;
  logic [7:0] m_cnt = 0;
  logic [1:0] p_op;
  logic [7:0] p_d;
  addsub_accumulator #(.W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .operand  (operand),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .acc      (acc),
    .carry    (carry),
    .ovf      (ovf),
    .op_cnt   (op_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_apply(input logic [1:0] o, input logic [7:0] d);
    int s, sa, sd;
    sa = $signed(m_acc);
    sd = $signed(d);
    case (o)
      2'b00: begin m_acc = 0; m_c = 0; m_v = 0; end
      2'b01: begin m_acc = d; m_c = 0; m_v = 0; end
      2'b10: begin
        s = int'(m_acc) + int'(d);
        m_c = s > 255;
        m_acc = 8'(s);
        m_v = (sa + sd > 127) || (sa + sd < -128);
      end
      default: begin
        s = int'(m_acc) - int'(d);
        m_c = m_acc >= d;
        m_acc = 8'(s);
        m_v = (sa - sd > 127) || (sa - sd < -128);
      end
    endcase
  endtask
  task automatic accept(input logic [1:0] o, input logic [7:0] d);
    for (int i = 0; i < 10 && !in_ready; i++) tick();
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1;
    op = o;
    operand = d;
    tick();
    in_valid = 0;
    op = 2'($urandom);
    operand = 8'($urandom);
    p_op = o;
    p_d = d;
  endtask
  task automatic exec_check();
    chk("exec_res_valid", res_valid, 0);
    chk("exec_in_ready", in_ready, 0);
    tick();
    model_apply(p_op, p_d);
    chk("hold_res_valid", res_valid, 1);
    chk("hold_in_ready", in_ready, 0);
    chk("acc", acc, m_acc);
    chk("carry", carry, m_c);
    chk("ovf", ovf, m_v);
  endtask
  task automatic release_res(input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("stall_res_valid", res_valid, 1);
      chk("stall_acc", acc, m_acc);
    end
    res_ready = 1;
    tick();
    res_ready = 0;
    m_cnt++;
    chk("op_cnt", op_cnt, m_cnt);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_res_valid", res_valid, 0);
  endtask
  task automatic do_op(input logic [1:0] o, input logic [7:0] d, input int hold);
    accept(o, d);
    exec_check();
    release_res(hold);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1;
    chk("rst_acc", acc, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    do_op(2'b01, 8'h05, 0);
    do_op(2'b10, 8'h03, 0);
    chk("load_add_acc", acc, 8'h08);
    chk("load_add_cnt", op_cnt, 2);
    do_op(2'b01, 8'h7F, 1);
    do_op(2'b10, 8'h01, 0);
    chk("ovf_case", {acc, carry, ovf}, {8'h80, 1'b0, 1'b1});
    do_op(2'b01, 8'hFF, 0);
    do_op(2'b10, 8'h01, 0);
    chk("wrap_add", {acc, carry, ovf}, {8'h00, 1'b1, 1'b0});
    do_op(2'b01, 8'h03, 0);
    do_op(2'b11, 8'h05, 0);
    chk("borrow_sub", {acc, carry, ovf}, {8'hFE, 1'b0, 1'b0});
    do_op(2'b01, 8'h80, 0);
    do_op(2'b11, 8'h01, 0);
    chk("ovf_sub", {acc, carry, ovf}, {8'h7F, 1'b1, 1'b1});
    do_op(2'b00, 8'h55, 0);
    chk("clr", {acc, carry, ovf}, 10'h0);
    accept(2'b01, 8'h20);
    exec_check();
    in_valid = 1;
    op = 2'b10;
    operand = 8'h10;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_res_valid", res_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_acc", acc, 8'h20);
    end
    release_res(0);
    tick();
    in_valid = 0;
    p_op = 2'b10;
    p_d = 8'h10;
    exec_check();
    chk("bp_acc_after", acc, 8'h30);
    release_res(0);
    accept(2'b10, 8'h22);
    rst_b = 0;
    tick();
    rst_b = 1;
    m_acc = 0;
    m_c = 0;
    m_v = 0;
    m_cnt = 0;
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_cnt", op_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_valid", res_valid, 0);
      tick();
    end
    for (int k = 0; k < 256; k++) begin
      do_op(2'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
      if (k == 254) chk("cnt_ff", op_cnt, 8'hFF);
    end
    chk("cnt_wrap", op_cnt, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
